// File: rtl/graphics_processor_if.sv
// Command / frame-buffer / image-ROM bundle for graphics_processor.
//   en, opcode, tl_x/tl_y, br_x/br_y, arg : command request from the initiator
//   finish                                : command complete (level)
//   vram_we, vram_addr, vram_data         : frame-buffer write port, one pixel per cycle
//   img_addr, img_data                    : image ROM read port (registered read, 1-cycle latency)
// master = initiator side (also models the ROM), slave = graphics_processor.
interface graphics_processor_if;
  logic        en;
  logic        opcode;
  logic [9:0]  tl_x;
  logic [8:0]  tl_y;
  logic [9:0]  br_x;
  logic [8:0]  br_y;
  logic [11:0] arg;
  logic        finish;
  logic        vram_we;
  logic [18:0] vram_addr;
  logic [11:0] vram_data;
  logic [18:0] img_addr;
  logic [11:0] img_data;

  modport master (
    output en, opcode, tl_x, tl_y, br_x, br_y, arg, img_data,
    input  finish, vram_we, vram_addr, vram_data, img_addr
  );

  modport slave (
    input  en, opcode, tl_x, tl_y, br_x, br_y, arg, img_data,
    output finish, vram_we, vram_addr, vram_data, img_addr
  );
endinterface

// File: rtl/graphics_processor.sv
// Rectangle fill / blit engine.
// Latches a command (opcode, corners, arg) when en is seen high in IDLE, clamps
// the corners to the screen, then walks the rectangle in raster order writing
// one pixel per cycle into the frame buffer:
//   opcode 0 : every pixel gets colour arg (RGB444)
//   opcode 1 : pixels copied from the image ROM starting at {arg,7'b0}
// finish stays high (gated by en) until the initiator drops en.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : graphics_processor_if.slave (command, frame-buffer, image ROM)
module graphics_processor #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input logic                 clk,
  input logic                 rst_n,
  graphics_processor_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FILL, BLIT_PRIME, BLIT, DONE} state_t;

  localparam logic [9:0]  X_MAX    = 10'(H_RES - 1);
  localparam logic [8:0]  Y_MAX    = 9'(V_RES - 1);
  localparam logic [18:0] ROW_STEP = 19'(H_RES);

  state_t      state;
  logic [9:0]  x_q, tl_x_q, br_x_q;
  logic [8:0]  y_q, br_y_q;
  logic [18:0] row_addr_q;   // address of (tl_x, y_q): base for the row wrap
  logic [18:0] addr_q;       // address of (x_q, y_q)
  logic [11:0] data_q;
  logic [18:0] img_addr_q;
  logic        we_q;
  logic        done_q;

  // Corner clamping and start address, evaluated only on the latch edge. The
  // constant multiply happens once per command, never per pixel.
  logic [9:0]  c_tl_x, c_br_x;
  logic [8:0]  c_tl_y, c_br_y;
  logic        empty;
  logic [18:0] start_addr;

  assign c_tl_x     = (bus.tl_x > X_MAX) ? X_MAX : bus.tl_x;
  assign c_br_x     = (bus.br_x > X_MAX) ? X_MAX : bus.br_x;
  assign c_tl_y     = (bus.tl_y > Y_MAX) ? Y_MAX : bus.tl_y;
  assign c_br_y     = (bus.br_y > Y_MAX) ? Y_MAX : bus.br_y;
  assign empty      = (c_tl_x > c_br_x) || (c_tl_y > c_br_y);
  assign start_addr = 19'(c_tl_y) * ROW_STEP + 19'(c_tl_x);

  // Raster step: next pixel along the row, or wrap to tl_x of the next row.
  logic [9:0]  nx_x;
  logic [8:0]  nx_y;
  logic [18:0] nx_row, nx_addr;
  logic        last_px, next_is_last;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nx_x    = x_q + 10'd1;
    nx_y    = y_q;
    nx_row  = row_addr_q;
    nx_addr = addr_q + 19'd1;
    if (x_q == br_x_q) begin
      nx_x    = tl_x_q;
      nx_y    = y_q + 9'd1;
      nx_row  = row_addr_q + ROW_STEP;
      nx_addr = row_addr_q + ROW_STEP;
    end
  end

  assign last_px      = (x_q == br_x_q) && (y_q == br_y_q);
  // The ROM address leads the pixel by one; stop advancing it once the
  // address for the final pixel has been issued.
  assign next_is_last = (nx_x == br_x_q) && (nx_y == br_y_q);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order. Datapath registers are
  // plain flops (no memories), so they are all reset to known values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      tl_x_q     <= '0;
      br_x_q     <= '0;
      br_y_q     <= '0;
      row_addr_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      img_addr_q <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          if (bus.en) begin
            tl_x_q     <= c_tl_x;
            br_x_q     <= c_br_x;
            br_y_q     <= c_br_y;
            x_q        <= c_tl_x;
            y_q        <= c_tl_y;
            row_addr_q <= start_addr;
            addr_q     <= start_addr;
            if (empty) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (!bus.opcode) begin
              state  <= FILL;
              we_q   <= 1'b1;
              data_q <= bus.arg;
            end else begin
              state      <= BLIT_PRIME;
              img_addr_q <= {bus.arg, 7'b0};
            end
          end
        end

        BLIT_PRIME: begin
          if (!bus.en) begin
            state <= IDLE;
          end else begin
            state <= BLIT;
            we_q  <= 1'b1;
            if (!last_px) img_addr_q <= img_addr_q + 19'd1;
          end
        end

        FILL, BLIT: begin
          if (!bus.en) begin
            state <= IDLE;
            we_q  <= 1'b0;
          end else if (last_px) begin
            state  <= DONE;
            we_q   <= 1'b0;
            done_q <= 1'b1;
          end else begin
            x_q        <= nx_x;
            y_q        <= nx_y;
            row_addr_q <= nx_row;
            addr_q     <= nx_addr;
            if (state == BLIT && !next_is_last) img_addr_q <= img_addr_q + 19'd1;
          end
        end

        DONE: begin
          if (!bus.en) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Both the write strobe and finish are gated by en so an abort or an en drop
  // takes effect in the same cycle, not one edge later.
  assign bus.vram_we   = we_q & bus.en;
  assign bus.finish    = done_q & bus.en;
  assign bus.vram_addr = addr_q;
  // During BLIT the pixel comes straight from the ROM's output register.
  assign bus.vram_data = (state == BLIT) ? bus.img_data : data_q;
  assign bus.img_addr  = img_addr_q;

endmodule

// File: tb/tb_graphics_processor.sv
// Self-checking bench for graphics_processor: table of directed commands with
// hand-derived results, hand-written multi-cycle sequences (blit prime, abort,
// reset mid-command) and randomized commands checked against a raster model.
module tb_graphics_processor;
  localparam int H = 640;
  localparam int V = 480;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  graphics_processor_if bus ();

  graphics_processor #(.H_RES(H), .V_RES(V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Image ROM contents: low bits are the address, upper address bits folded in.
  function automatic logic [11:0] rom_f(input logic [18:0] a);
    return a[11:0] ^ {a[18:12], 5'b0};
  endfunction

  always @(posedge clk) bus.img_data <= rom_f(bus.img_addr);

  int tests = 0;
  int fails = 0;
  int wr_total = 0;
  int exp_total = 0;

  always @(negedge clk) if (rst_n && bus.vram_we) wr_total++;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  typedef struct {
    logic        op;
    logic [9:0]  tlx;
    logic [8:0]  tly;
    logic [9:0]  brx;
    logic [8:0]  bry;
    logic [11:0] arg;
    int          n;
    int          first;
    int          last;
    int          first_data;
    int          fin;
  } vec_t;

  int exp_a[$], exp_d[$];
  int act_a[$], act_d[$], act_k[$];

  // Reference: enumerate the clamped rectangle row by row.
  task automatic model(input logic op, input int tlx, input int tly, input int brx,
                       input int bry, input logic [11:0] arg, output int fin_k);
    int cx0, cx1, cy0, cy1, k;
    logic [18:0] base;
    exp_a.delete();
    exp_d.delete();
    cx0 = (tlx > H - 1) ? H - 1 : tlx;
    cx1 = (brx > H - 1) ? H - 1 : brx;
    cy0 = (tly > V - 1) ? V - 1 : tly;
    cy1 = (bry > V - 1) ? V - 1 : bry;
    base = {arg, 7'b0};
    k = 0;
    for (int y = cy0; y <= cy1; y++)
      for (int x = cx0; x <= cx1; x++) begin
        exp_a.push_back(y * H + x);
        exp_d.push_back(op ? int'(rom_f(base + 19'(k))) : int'(arg));
        k++;
      end
    fin_k = (k == 0) ? 1 : (op ? k + 2 : k + 1);
    exp_total += k;
  endtask

  task automatic issue(input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                       input logic [9:0] brx, input logic [8:0] bry, input logic [11:0] arg);
    @(posedge clk);
    #1;
    bus.opcode = op;
    bus.tl_x   = tlx;
    bus.tl_y   = tly;
    bus.br_x   = brx;
    bus.br_y   = bry;
    bus.arg    = arg;
    bus.en     = 1'b1;
  endtask

  // Waits for the latch edge, scrambles the command inputs, then records writes
  // per cycle (k = 1 is the cycle after the latch edge) until finish or max_k.
  task automatic observe(input int max_k, output int fin_k);
    act_a.delete();
    act_d.delete();
    act_k.delete();
    @(posedge clk);
    #1;
    bus.opcode = 1'($urandom);
    bus.tl_x   = 10'($urandom);
    bus.tl_y   = 9'($urandom);
    bus.br_x   = 10'($urandom);
    bus.br_y   = 9'($urandom);
    bus.arg    = 12'($urandom);
    fin_k = -1;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      if (bus.vram_we) begin
        act_a.push_back(int'(bus.vram_addr));
        act_d.push_back(int'(bus.vram_data));
        act_k.push_back(k);
      end
      if (bus.finish) begin
        fin_k = k;
        break;
      end
    end
  endtask

  // Holds en in DONE for a few cycles, then drops it for exactly one cycle.
  task automatic release_cmd(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".finish_hold"}, int'(bus.finish), 1);
    end
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    #1;
    check({tag, ".finish_drop"}, int'(bus.finish), 0);
  endtask

  task automatic run_and_check(input string tag, input logic op, input logic [9:0] tlx,
                               input logic [8:0] tly, input logic [9:0] brx,
                               input logic [8:0] bry, input logic [11:0] arg,
                               input int hold, output int fin_k);
    int fin_exp, errs, first_k, m;
    model(op, int'(tlx), int'(tly), int'(brx), int'(bry), arg, fin_exp);
    issue(op, tlx, tly, brx, bry, arg);
    observe(exp_a.size() + 10, fin_k);
    first_k = op ? 2 : 1;
    errs = 0;
    m = (act_a.size() < exp_a.size()) ? act_a.size() : exp_a.size();
    for (int i = 0; i < m; i++)
      if (act_a[i] != exp_a[i] || act_d[i] != exp_d[i] || act_k[i] != first_k + i) errs++;
    check({tag, ".count"}, act_a.size(), exp_a.size());
    check({tag, ".write_errs"}, errs, 0);
    check({tag, ".finish_cycle"}, fin_k, fin_exp);
    release_cmd(tag, hold);
  endtask

  vec_t tbl[8];

  initial begin
    int fin_k, w;
    tbl[0] = '{1'b0, 10'd2,    9'd1,   10'd3,    9'd2,   12'hFFF, 4,   642,    1283,   'hFFF, 5};
    tbl[1] = '{1'b0, 10'd630,  9'd0,   10'd700,  9'd0,   12'h0A5, 10,  630,    639,    'h0A5, 11};
    tbl[2] = '{1'b0, 10'd5,    9'd5,   10'd4,    9'd5,   12'h111, 0,   0,      0,      0,     1};
    tbl[3] = '{1'b1, 10'd0,    9'd0,   10'd1,    9'd1,   12'h001, 4,   0,      641,    128,   6};
    tbl[4] = '{1'b0, 10'd0,    9'd479, 10'd639,  9'd479, 12'h123, 640, 306560, 307199, 'h123, 641};
    tbl[5] = '{1'b0, 10'd1023, 9'd511, 10'd1023, 9'd511, 12'hABC, 1,   307199, 307199, 'hABC, 2};
    tbl[6] = '{1'b1, 10'd638,  9'd478, 10'd900,  9'd500, 12'hFFF, 4,   306558, 307199, 'h060, 6};
    tbl[7] = '{1'b1, 10'd0,    9'd10,  10'd5,    9'd9,   12'h222, 0,   0,      0,      0,     1};

    // Reset state, with en high to show finish is forced low too.
    rst_n = 1'b0;
    bus.en = 1'b1; bus.opcode = 1'b0; bus.arg = '0;
    bus.tl_x = '0; bus.tl_y = '0; bus.br_x = '0; bus.br_y = '0;
    #3;
    check("reset.vram_we",   int'(bus.vram_we),   0);
    check("reset.finish",    int'(bus.finish),    0);
    check("reset.vram_addr", int'(bus.vram_addr), 0);
    check("reset.vram_data", int'(bus.vram_data), 0);
    check("reset.img_addr",  int'(bus.img_addr),  0);
    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table.
    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      run_and_check(tag, tbl[i].op, tbl[i].tlx, tbl[i].tly, tbl[i].brx, tbl[i].bry,
                    tbl[i].arg, 2, fin_k);
      check({tag, ".tbl_count"}, act_a.size(), tbl[i].n);
      check({tag, ".tbl_finish"}, fin_k, tbl[i].fin);
      if (tbl[i].n > 0 && act_a.size() > 0) begin
        check({tag, ".tbl_first_addr"}, act_a[0], tbl[i].first);
        check({tag, ".tbl_last_addr"}, act_a[act_a.size() - 1], tbl[i].last);
        check({tag, ".tbl_first_data"}, act_d[0], tbl[i].first_data);
      end
    end

    // Blit prime cycle: no write, first ROM address issued, then data follows.
    issue(1'b1, 10'd0, 9'd0, 10'd1, 9'd1, 12'h001);
    exp_total += 4;
    @(posedge clk);
    @(negedge clk);
    check("prime.vram_we",  int'(bus.vram_we),  0);
    check("prime.img_addr", int'(bus.img_addr), 128);
    @(negedge clk);
    check("blit0.vram_we",   int'(bus.vram_we),   1);
    check("blit0.vram_addr", int'(bus.vram_addr), 0);
    check("blit0.vram_data", int'(bus.vram_data), 128);
    check("blit0.img_addr",  int'(bus.img_addr),  129);
    fin_k = -1;
    for (int k = 3; k <= 12; k++) begin
      @(negedge clk);
      if (bus.finish) begin
        fin_k = k;
        break;
      end
    end
    check("prime.finish_cycle", fin_k, 6);
    release_cmd("prime", 0);

    // Abort: en drops after three writes.
    issue(1'b0, 10'd10, 9'd10, 10'd29, 9'd19, 12'h0F0);
    exp_total += 3;
    @(posedge clk);
    w = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.vram_we) w++;
    end
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    @(negedge clk);
    check("abort.we_low", int'(bus.vram_we), 0);
    check("abort.writes", w, 3);
    run_and_check("after_abort", 1'b0, 10'd100, 9'd3, 10'd102, 9'd3, 12'h456, 0, fin_k);

    // Reset mid-fill: outputs drop at once, nothing written until a new en.
    issue(1'b0, 10'd0, 9'd100, 10'd99, 9'd100, 12'h777);
    exp_total += 2;
    @(posedge clk);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.vram_we",   int'(bus.vram_we),   0);
    check("midrst.finish",    int'(bus.finish),    0);
    check("midrst.vram_addr", int'(bus.vram_addr), 0);
    check("midrst.vram_data", int'(bus.vram_data), 0);
    check("midrst.img_addr",  int'(bus.img_addr),  0);
    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    w = wr_total;
    repeat (4) @(negedge clk);
    check("midrst.no_writes", wr_total - w, 0);
    run_and_check("after_rst", 1'b1, 10'd7, 9'd7, 10'd9, 9'd8, 12'h3C4, 0, fin_k);

    // Randomized back-to-back commands.
    for (int i = 0; i < 24; i++) begin
      int tx, ty, wd, ht;
      tx = $urandom_range(1, 660);
      ty = $urandom_range(1, 490);
      wd = $urandom_range(0, 12);
      ht = $urandom_range(0, 6);
      run_and_check($sformatf("rnd%0d", i), 1'($urandom), 10'(tx), 9'(ty),
                    10'(tx + wd - 1), 9'(ty + ht - 1), 12'($urandom), 0, fin_k);
    end

    repeat (2) @(posedge clk);
    check("total_writes", wr_total, exp_total);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/graphics_processor.md
GRAPHICS_PROCESSOR -- requirements
Module: graphics_processor

Interface
REQ-001 Parameters SHALL be: H_RES default 640, screen width in pixels; V_RES default 480, screen height in pixels.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; ports as follows.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 en  in  1  command request, held high by initiator until finish seen.
REQ-006 opcode  in  1  0 = solid fill with colour arg; 1 = blit from image ROM.
REQ-007 tl_x  in  10 / tl_y  in  9  top-left corner, inclusive.
REQ-008 br_x  in  10 / br_y  in  9  bottom-right corner, inclusive.
REQ-009 arg  in  12  fill colour (opcode 0, RGB444) or image base index (opcode 1).
REQ-010 finish  out  1  command complete; level signal.
REQ-011 vram_we  out  1 / vram_addr  out  19 / vram_data  out  12  frame-buffer write port, one pixel per asserted cycle.
REQ-012 img_addr  out  19 / img_data  in  12  image ROM read port, registered read, 1-cycle latency.

Function
REQ-013 States SHALL be IDLE, FILL, BLIT_PRIME, BLIT, DONE.
REQ-014 IDLE: on edge with en=1, latch opcode, corners, arg; go FILL (opcode 0) or BLIT_PRIME (opcode 1).
REQ-015 Corners SHALL be clamped at latch: x to H_RES-1, y to V_RES-1.
REQ-016 Empty rectangle (clamped tl_x>br_x or tl_y>br_y) SHALL go directly to DONE, zero writes.
REQ-017 Traversal SHALL be raster order: x from tl_x to br_x, then y+1, x back to tl_x; last pixel (br_x,br_y) then DONE.
REQ-018 vram_addr SHALL equal y*H_RES+x, computed incrementally (row base += H_RES per row); no per-pixel multiplier.
REQ-019 FILL: vram_we=1 and vram_data=arg every cycle in FILL; N pixels take exactly N cycles.
REQ-020 BLIT source address SHALL start at {arg,7'b0} truncated to 19 bits, increment by 1 per pixel.
REQ-021 BLIT_PRIME: one cycle issuing first img_addr, no write; BLIT: write img_data from address issued previous cycle while issuing next; N pixels take N+1 cycles.
REQ-022 Latency: en sampled at edge E0 -> first write in cycle after E0; finish high in cycle after last write.
REQ-023 finish SHALL equal done_reg AND en (combinational gate), so it drops in the same cycle en drops.
REQ-024 DONE: stay while en=1; en=0 -> IDLE next edge; en may re-assert after a single low cycle and SHALL be accepted.
REQ-025 en=0 during FILL/BLIT_PRIME/BLIT SHALL abort: no further writes, IDLE next edge.
REQ-026 Input changes after latch SHALL NOT affect the running command.
REQ-027 vram_we SHALL be 0 in IDLE, BLIT_PRIME, DONE.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, finish=0, vram_we=0, vram_addr=0, vram_data=0, img_addr=0, regardless of state.
REQ-029 Reset mid-command SHALL discard it; after release, en=1 is required to start anew.

Verification
REQ-030 Fill opcode 0, (2,1)-(3,2), arg 12'hFFF -> 4 writes, addrs 642,643,1282,1283, data FFF, finish cycle 5 after latch.
REQ-031 Full-screen fill (0,0)-(639,479) -> 307200 consecutive writes, last addr 307199, then finish.
REQ-032 Clamp: fill (630,0)-(700,0) -> 10 writes, addrs 630..639; empty (5,5)-(4,5) -> 0 writes, finish next cycle.
REQ-033 Blit opcode 1, (0,0)-(1,1), arg 1, ROM data=addr[11:0] -> img_addr 128..131, writes at 0,1,640,641 with data 128..131, one prime cycle.
REQ-034 Back-to-back: drop en one cycle after finish, re-issue -> finish low that cycle, second command accepted, no lost or duplicate writes.
REQ-035 Assert rst_n=0 mid-fill -> vram_we and finish 0 immediately, no writes until new en.
